// File: rtl/tpu_pkg.sv
// Shared sizes, lane type and sequencer states for the systolic array controller.
package tpu_pkg;
  localparam int SIZE   = 4;
  localparam int DATA_W = 8;
  localparam int K_W    = 8;

  localparam int SZ_W  = $clog2(SIZE + 1);
  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  // Phase counter must hold both the K loop and the skew/drain lengths.
  localparam int CNT_W = (K_W > $clog2(2 * SIZE + 1)) ? K_W : $clog2(2 * SIZE + 1);

  typedef logic [DATA_W-1:0] lane_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    SKEW  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } seq_state_t;

  function automatic int skew_len(input int i);
    return i;
  endfunction
endpackage

// File: rtl/skew_line.sv
// DEPTH-stage delay line with asynchronous active-low clear; DEPTH = 0 is a wire.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign dout = din;
    end else begin : g_shift
      logic [DATA_W-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else begin
          stage[0] <= din;
          for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for the SIZE x SIZE systolic array: operand fetch, lane skewing,
// accumulator control and bottom-up result row drain.
module systolic_seq_ctrl
  import tpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [SZ_W-1:0]        size_m,
  input  logic [SZ_W-1:0]        size_n,
  input  logic [K_W-1:0]         size_k,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   op_rd_en,
  output logic [K_W-1:0]         op_rd_idx,
  input  logic [SIZE*DATA_W-1:0] a_rd_data,
  input  logic [SIZE*DATA_W-1:0] b_rd_data,
  output logic                   arr_reset,
  output logic                   arr_through,
  output logic [SIZE*DATA_W-1:0] left_in,
  output logic [SIZE*DATA_W-1:0] top_in,
  input  logic [SIZE*DATA_W-1:0] down_out,
  output logic                   res_valid,
  output logic [ROW_W-1:0]       res_row,
  output logic [SIZE*DATA_W-1:0] res_data,
  output logic [2:0]             dbg_state
);
  // Handshake: start is sampled only in IDLE; a good request moves to CLEAR on
  // that edge, a bad one pulses err for one cycle. done pulses for one cycle in
  // DONE, and busy covers CLEAR..DRAIN. There is no backpressure on res_valid.

  seq_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [SZ_W-1:0]  m_q, n_q;
  logic [K_W-1:0]   k_q;
  logic             err_next, load, bad_size;
  logic             rd_en_d;
  lane_t            cap_a [SIZE];
  lane_t            cap_b [SIZE];
  logic             drain_out;
  logic [CNT_W-1:0] drain_row;

  assign bad_size = (size_m == '0) || (size_n == '0) || (size_k == '0) ||
                    (size_m > SZ_W'(SIZE)) || (size_n > SZ_W'(SIZE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      m_q   <= '0;
      n_q   <= '0;
      k_q   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      err   <= err_next;
      if (load) begin
        m_q <= size_m;
        n_q <= size_n;
        k_q <= size_k;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (start) begin
          if (bad_size) begin
            err_next = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = CLEAR;
          end
        end
      end
      CLEAR: begin
        cnt_next   = '0;
        state_next = FEED;
      end
      FEED: begin
        if (cnt == CNT_W'(k_q) - CNT_W'(1)) begin
          cnt_next   = '0;
          state_next = SKEW;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      SKEW: begin
        if (cnt == CNT_W'(2 * SIZE - 2)) begin
          cnt_next   = '0;
          state_next = DRAIN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(SIZE)) begin
          cnt_next   = '0;
          state_next = DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Drain cycle 0 is spent by the array switching to shift-out; rows follow.
  assign drain_out = (state == DRAIN) && (cnt != '0);
  assign drain_row = CNT_W'(SIZE) - cnt;

  always_comb begin
    busy        = (state == CLEAR) || (state == FEED) || (state == SKEW) || (state == DRAIN);
    done        = (state == DONE);
    op_rd_en    = (state == FEED);
    op_rd_idx   = op_rd_en ? cnt[K_W-1:0] : '0;
    arr_reset   = (state == IDLE) || (state == CLEAR) || (state == DONE);
    arr_through = (state == DRAIN);
    res_valid   = drain_out && (drain_row < CNT_W'(m_q));
    res_row     = drain_out ? drain_row[ROW_W-1:0] : '0;
    res_data    = '0;
    for (int j = 0; j < SIZE; j++) begin
      if (drain_out && (j < int'(n_q))) res_data[j*DATA_W +: DATA_W] = down_out[j*DATA_W +: DATA_W];
    end
  end

  assign dbg_state = state;

  // Capture the cache return one cycle after the request; unused lanes and
  // cycles without a request load zero so idle slots never carry stale data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_en_d <= 1'b0;
      for (int i = 0; i < SIZE; i++) begin
        cap_a[i] <= '0;
        cap_b[i] <= '0;
      end
    end else begin
      rd_en_d <= op_rd_en;
      for (int i = 0; i < SIZE; i++) begin
        cap_a[i] <= (rd_en_d && (i < int'(m_q))) ? a_rd_data[i*DATA_W +: DATA_W] : '0;
        cap_b[i] <= (rd_en_d && (i < int'(n_q))) ? b_rd_data[i*DATA_W +: DATA_W] : '0;
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_lane
    skew_line #(.DEPTH(skew_len(i)), .DATA_W(DATA_W)) u_left (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (cap_a[i]),
      .dout    (left_in[i*DATA_W +: DATA_W])
    );
    skew_line #(.DEPTH(skew_len(i)), .DATA_W(DATA_W)) u_top (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (cap_b[i]),
      .dout    (top_in[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Self-checking bench: cache/array stubs plus a cycle-indexed reference of the job timeline.
module tb_systolic_seq_ctrl;
  import tpu_pkg::*;

  localparam int BW = SIZE * DATA_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [SZ_W-1:0]   size_m, size_n;
  logic [K_W-1:0]    size_k;
  logic              busy, done, err, op_rd_en;
  logic [K_W-1:0]    op_rd_idx;
  logic [BW-1:0]     a_rd_data, b_rd_data;
  logic              arr_reset, arr_through;
  logic [BW-1:0]     left_in, top_in, down_out;
  logic              res_valid;
  logic [ROW_W-1:0]  res_row;
  logic [BW-1:0]     res_data;
  logic [2:0]        dbg_state;

  always #5 clk = ~clk;

  systolic_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .size_m(size_m), .size_n(size_n), .size_k(size_k),
    .busy(busy), .done(done), .err(err),
    .op_rd_en(op_rd_en), .op_rd_idx(op_rd_idx),
    .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
    .arr_reset(arr_reset), .arr_through(arr_through),
    .left_in(left_in), .top_in(top_in), .down_out(down_out),
    .res_valid(res_valid), .res_row(res_row), .res_data(res_data),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int jm, jn, jk;
  int thr_run = 0;
  int res_seen;
  logic [DATA_W-1:0] a_mat [SIZE][256];
  logic [DATA_W-1:0] b_mat [256][SIZE];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // C entry as the array would accumulate it, wrapped to the lane width.
  function automatic logic [DATA_W-1:0] c_val(input int r, input int c);
    int acc = 0;
    for (int k = 0; k < jk; k++) acc += int'(a_mat[r][k]) * int'(b_mat[k][c]);
    return DATA_W'(acc);
  endfunction

  function automatic logic [BW-1:0] stub_row(input int r);
    logic [BW-1:0] v = '0;
    for (int c = 0; c < SIZE; c++) v[c*DATA_W +: DATA_W] = c_val(r, c);
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_row(input int r);
    logic [BW-1:0] v = '0;
    for (int c = 0; c < jn; c++) v[c*DATA_W +: DATA_W] = c_val(r, c);
    return v;
  endfunction

  // Column k of A reaches lane i at s = k + 3 + i (request, return, capture, skew).
  function automatic logic [BW-1:0] exp_left(input int s);
    logic [BW-1:0] v = '0;
    for (int i = 0; i < SIZE; i++) begin
      int k = s - 3 - i;
      if (i < jm && k >= 0 && k < jk) v[i*DATA_W +: DATA_W] = a_mat[i][k];
    end
    return v;
  endfunction

  function automatic logic [BW-1:0] exp_top(input int s);
    logic [BW-1:0] v = '0;
    for (int j = 0; j < SIZE; j++) begin
      int k = s - 3 - j;
      if (j < jn && k >= 0 && k < jk) v[j*DATA_W +: DATA_W] = b_mat[k][j];
    end
    return v;
  endfunction

  // One clock: cache stub answers last cycle's request, array stub presents
  // row SIZE-d on the d-th consecutive through cycle; garbage otherwise.
  task automatic tick();
    logic en, thr;
    logic [K_W-1:0] idx;
    en  = op_rd_en;
    idx = op_rd_idx;
    thr = arr_through;
    @(posedge clk);
    #1;
    if (en) begin
      for (int i = 0; i < SIZE; i++) begin
        a_rd_data[i*DATA_W +: DATA_W] = a_mat[i][idx];
        b_rd_data[i*DATA_W +: DATA_W] = b_mat[idx][i];
      end
    end else begin
      a_rd_data = BW'($urandom);
      b_rd_data = BW'($urandom);
    end
    thr_run = thr ? thr_run + 1 : 0;
    if (thr_run >= 1 && thr_run <= SIZE) down_out = stub_row(SIZE - thr_run);
    else down_out = BW'($urandom);
    #1;
  endtask

  task automatic check_cycle(input int s);
    int t = jk + 3 * SIZE + 1;
    int d = s - (jk + 2 * SIZE + 1);
    logic exp_en = (s >= 1) && (s <= jk);
    logic exp_valid = (d >= 0) && (d < SIZE) && ((SIZE - 1 - d) < jm);
    chk($sformatf("busy@%0d", s), busy, s < t);
    chk($sformatf("done@%0d", s), done, s == t);
    chk($sformatf("err@%0d", s), err, 1'b0);
    chk($sformatf("op_rd_en@%0d", s), op_rd_en, exp_en);
    chk($sformatf("arr_reset@%0d", s), arr_reset, (s == 0) || (s >= t));
    chk($sformatf("arr_through@%0d", s), arr_through, (s >= jk + 2 * SIZE) && (s <= jk + 3 * SIZE));
    chk($sformatf("left_in@%0d", s), left_in, exp_left(s));
    chk($sformatf("top_in@%0d", s), top_in, exp_top(s));
    chk($sformatf("res_valid@%0d", s), res_valid, exp_valid);
    if (exp_en) chk($sformatf("op_rd_idx@%0d", s), op_rd_idx, s - 1);
    if (exp_valid) begin
      chk($sformatf("res_row@%0d", s), res_row, SIZE - 1 - d);
      chk($sformatf("res_data@%0d", s), res_data, exp_row(SIZE - 1 - d));
    end
    if (res_valid) res_seen++;
  endtask

  task automatic run_job(input int m, input int n, input int k, input bit hold);
    jm = m; jn = n; jk = k; res_seen = 0;
    size_m = SZ_W'(m); size_n = SZ_W'(n); size_k = K_W'(k);
    start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    for (int s = 0; s <= jk + 3 * SIZE + 2; s++) begin
      check_cycle(s);
      if (s <= jk + 3 * SIZE + 1) tick();
    end
    chk($sformatf("res_count m=%0d k=%0d", m, k), res_seen, m);
  endtask

  task automatic fill_random();
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < 256; k++) begin
        a_mat[r][k] = DATA_W'($urandom);
        b_mat[k][r] = DATA_W'($urandom);
      end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_op_rd_en"}, op_rd_en, 1'b0);
    chk({tag, "_op_rd_idx"}, op_rd_idx, 0);
    chk({tag, "_arr_reset"}, arr_reset, 1'b1);
    chk({tag, "_arr_through"}, arr_through, 1'b0);
    chk({tag, "_left_in"}, left_in, 0);
    chk({tag, "_top_in"}, top_in, 0);
    chk({tag, "_res_valid"}, res_valid, 1'b0);
    chk({tag, "_res_row"}, res_row, 0);
    chk({tag, "_res_data"}, res_data, 0);
  endtask

  task automatic err_case(input int m, input int n, input int k);
    size_m = SZ_W'(m); size_n = SZ_W'(n); size_k = K_W'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("err_pulse m%0d n%0d k%0d", m, n, k), err, 1'b1);
    chk($sformatf("err_busy m%0d n%0d k%0d", m, n, k), busy, 1'b0);
    tick();
    chk($sformatf("err_clear m%0d n%0d k%0d", m, n, k), err, 1'b0);
    chk($sformatf("err_idle m%0d n%0d k%0d", m, n, k), busy, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    size_m = '0; size_n = '0; size_k = '0;
    a_rd_data = '0; b_rd_data = '0; down_out = '0;
    jm = 1; jn = 1; jk = 1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // Reset mid-drain: everything returns to reset values immediately, no done.
    fill_random();
    jm = 3; jn = 3; jk = 5;
    size_m = 3'd3; size_n = 3'd3; size_k = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int s = 0; s <= jk + 2 * SIZE + 2; s++) begin
      check_cycle(s);
      if (s < jk + 2 * SIZE + 2) tick();
    end
    reset_n = 1'b0;
    #1;
    chk_reset_vals("mid_drain");
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_hold_done%0d", c), done, 1'b0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst_done%0d", c), done, 1'b0);
      chk($sformatf("post_rst_busy%0d", c), busy, 1'b0);
    end

    err_case(0, 2, 3);
    err_case(2, 5, 3);
    err_case(2, 2, 0);
    err_case(2, 0, 3);

    // M=2 N=1 K=3 worked example.
    fill_random();
    for (int k = 0; k < 3; k++) begin
      a_mat[0][k] = DATA_W'(k + 1);
      a_mat[1][k] = DATA_W'(k + 4);
      b_mat[k][0] = DATA_W'(k + 7);
    end
    run_job(2, 1, 3, 1'b0);

    // Identity A: result rows equal B rows.
    fill_random();
    for (int r = 0; r < SIZE; r++)
      for (int k = 0; k < SIZE; k++) a_mat[r][k] = (r == k) ? DATA_W'(1) : DATA_W'(0);
    run_job(SIZE, SIZE, SIZE, 1'b0);

    // K=1 skew staircase.
    fill_random();
    for (int i = 0; i < SIZE; i++) begin
      a_mat[i][0] = DATA_W'(i + 1);
      b_mat[0][i] = DATA_W'(i + 5);
    end
    run_job(SIZE, SIZE, 1, 1'b0);

    // start held through busy; the next job launches straight from IDLE.
    fill_random();
    run_job(3, 2, 6, 1'b1);
    fill_random();
    run_job(4, 3, 5, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_job($urandom_range(1, SIZE), $urandom_range(1, SIZE), $urandom_range(1, 12), 1'b0);
    end

    fill_random();
    run_job(1, 1, 255, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the SIZE x SIZE systolic `array`. It accepts one matrix-multiply job (C = A[M x K] * B[K x N]) through a start/done handshake and reads operand slices from the A/B caches. It drives skewed `left_in`/`top_in` lanes and the array `reset`/`through` controls, then streams result rows of C out to the C cache. It is the controller that sits between the operand/result caches and `array` in the TPU top.

Parameters:
SIZE, 4, array dimension (rows = columns = SIZE)
DATA_W, 8, operand/result lane width
K_W, 8, width of the K dimension count (K max = 2**K_W - 1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled only in IDLE
size_m  in  $clog2(SIZE+1)  rows of A used (1..SIZE)
size_n  in  $clog2(SIZE+1)  columns of B used (1..SIZE)
size_k  in  K_W  inner dimension (1..2**K_W-1)
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse: start rejected (bad size)
op_rd_en  out  1  operand read strobe
op_rd_idx  out  K_W  k index: requests A[*][k] and B[k][*]
a_rd_data  in  SIZE x DATA_W  column k of A, valid 1 cycle after op_rd_en
b_rd_data  in  SIZE x DATA_W  row k of B, valid 1 cycle after op_rd_en
arr_reset  out  1  array accumulator clear
arr_through  out  1  array shift-out mode
left_in  out  SIZE x DATA_W  to array left_in
top_in  out  SIZE x DATA_W  to array top_in
down_out  in  SIZE x DATA_W  from array down_out
res_valid  out  1  result row write strobe
res_row  out  $clog2(SIZE)  C row index
res_data  out  SIZE x DATA_W  C row (lanes >= size_n forced 0)

Behaviour:
- Clock and reset: one clock clk; reset_n is asynchronous and active-low. Reset values: state IDLE; busy, done, err, op_rd_en, res_valid, arr_through = 0; arr_reset = 1; all lanes, indices and counters = 0; skew registers cleared.
- Reset mid-job: the job is abandoned with no done pulse. Outputs return to their reset values immediately.
- FSM: IDLE -> CLEAR -> FEED -> SKEW -> DRAIN -> DONE -> IDLE.
- IDLE:
  - arr_reset = 1; busy = 0.
  - start with size_m, size_n or size_k = 0, or size_m or size_n > SIZE: err pulses 1 cycle and the FSM stays in IDLE.
  - Valid start: latch the sizes, go to CLEAR.
  - start outside IDLE is ignored.
- CLEAR (1 cycle): busy = 1; arr_reset = 1; op_rd_en = 0.
- FEED (size_k cycles):
  - arr_reset = 0; op_rd_en = 1; op_rd_idx = 0, 1, ..., size_k-1.
- Skew pipeline (runs in FEED and SKEW):
  - The returned column/row is written 1 cycle after op_rd_en.
  - Lane i of left_in is a_rd_data[i] delayed i further cycles; lane j of top_in is b_rd_data[j] delayed j cycles.
  - Lane 0 is combinational from the capture register.
  - Lanes i >= size_m (left) and j >= size_n (top) are forced to 0.
  - Lanes carry 0 whenever no valid data occupies that delay slot.
- SKEW (2*SIZE-1 cycles): op_rd_en = 0; zeros are fed while the last products propagate to PE(SIZE-1, SIZE-1).
- DRAIN (SIZE+1 cycles):
  - arr_through = 1.
  - Array contract: down_out presents row SIZE-1-d on drain cycle d+1 (d = 0..SIZE-1).
  - On drain cycle d+1: res_row = SIZE-1-d; res_data = down_out; res_valid = 1 only if SIZE-1-d < size_m.
  - Rows therefore emerge bottom row first.
- DONE (1 cycle): done = 1; busy = 0; arr_through = 0; arr_reset = 1; then IDLE.
  - A new start is accepted in the IDLE cycle after DONE.
- Latency: done rises exactly size_k + 3*SIZE + 1 cycles after the accepting start edge. busy is high from the edge after start up to, but excluding, the DONE cycle.
- Arithmetic and widths:
  - Phase counters are sized to hold max(size_k, 2*SIZE).
  - op_rd_idx wraps are impossible because FEED ends at size_k-1.
  - No saturation in this block; accumulation width belongs to `array`.

Decomposition:
- Package tpu_pkg:
  - localparams SIZE, DATA_W, K_W;
  - typedef lane_t (logic [DATA_W-1:0]);
  - typedef enum seq_state_t {IDLE, CLEAR, FEED, SKEW, DRAIN, DONE};
  - function skew_len(i) returning i.
- Sub-module skew_line #(DEPTH, DATA_W): a DEPTH-stage shift register with async active-low clear. It is instantiated per lane for left and top, with DEPTH = lane index. DEPTH = 0 is a pass-through.

Test Plan:
1. Reset and error check. Assert reset_n low during DRAIN -> outputs at reset values the same cycle, no done. Then start with size_m = 0 -> err pulse 1 cycle, busy stays 0.
2. SIZE=4, M=2, N=1, K=3, A = {1,2,3; 4,5,6}, B = {7,8,9}ᵀ:
   - op_rd_idx reads 0, 1, 2;
   - res_valid for row 1 (data lane0 = 122), then row 0 (lane0 = 50), other lanes 0;
   - done 16 cycles after start.
3. Full 4x4x4 with A = identity, B = random -> four res rows in order 3, 2, 1, 0 equal to B rows; done at cycle 17.
4. Skew check, K=1, SIZE=4, a_rd_data = {1,2,3,4}, b = {5,6,7,8}:
   - left_in lane i is non-zero exactly once, i cycles after lane 0;
   - top lane j likewise.
5. Back-to-back jobs, with start also held high during busy -> the busy-time start is ignored, the second job starts only from IDLE, and results match.
6. K=255, M=N=1 -> done at 255+13 = 268 cycles; exactly one res_valid (row 0); op_rd_idx ends at 254.
